// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: operand width, multiply/divide op codes
// and the multiply/divide FSM state encoding.
package mips_pkg;
  localparam int W = 32;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;
endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate: y = en ? -x : x.
module mdu_negate #(
  parameter int N = 32
) (
  input  logic         en,
  input  logic [N-1:0] x,
  output logic [N-1:0] y
);
  assign y = en ? ((~x) + N'(1)) : x;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO: radix-2 shift-add
// multiply and restoring divide on magnitudes, sign fixed in a final cycle.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  mdu_state_e state_q, state_d;
  logic [4:0]  cnt_q;
  // p_q holds {partial product/remainder (33b), multiplier/dividend (32b)}
  logic [64:0] p_q;
  logic [31:0] m_q;
  logic        div_q, neg_q, neg_r, dz_q;

  logic        is_signed;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift;
  logic [33:0] div_diff;
  logic [64:0] mul_next, div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);

  mdu_negate #(.N(32)) u_neg_a (.en(is_signed & a[31]), .x(a), .y(a_mag));
  mdu_negate #(.N(32)) u_neg_b (.en(is_signed & b[31]), .x(b), .y(b_mag));

  // Multiply step: add multiplicand if multiplier LSB set, then shift right.
  assign mul_sum  = p_q[64:32] + (p_q[0] ? {1'b0, m_q} : 33'd0);
  assign mul_next = {1'b0, mul_sum, p_q[31:1]};

  // Divide step: shift in next dividend bit, trial subtract, restore on borrow.
  assign div_shift = {p_q[63:32], p_q[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, m_q};
  assign div_next  = div_diff[33] ? {div_shift, p_q[30:0], 1'b0}
                                  : {div_diff[32:0], p_q[30:0], 1'b1};

  mdu_negate #(.N(64)) u_fix_prod (.en(neg_q), .x(p_q[63:0]),  .y(prod_fix));
  mdu_negate #(.N(32)) u_fix_quo  (.en(neg_q), .x(p_q[31:0]),  .y(quo_fix));
  mdu_negate #(.N(32)) u_fix_rem  (.en(neg_r), .x(p_q[63:32]), .y(rem_fix));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !op[2]) state_d = RUN;
      RUN:     if (cnt_q == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      p_q     <= '0;
      m_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              p_q   <= {33'd0, a_mag};
              m_q   <= b_mag;
              div_q <= op[1];
              neg_q <= is_signed & (a[31] ^ b[31]);
              neg_r <= is_signed & a[31];
              dz_q  <= (b == '0);
              cnt_q <= 5'd0;
            end else if (op == MDU_MTHI) begin
              hi <= a;
            end else if (op == MDU_MTLO) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          p_q   <= div_q ? div_next : mul_next;
          cnt_q <= cnt_q + 5'd1;
        end
        FIX: begin
          if (div_q) begin
            hi <= rem_fix;
            lo <= dz_q ? '1 : quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, hand-written corner
// sequences and random operations checked against an arithmetic model.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int passes = 0;
  logic [31:0] m_hi, m_lo;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
  } vec_t;
  vec_t vecs[$];

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] x, y,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, q, r;
    logic [63:0] p, pr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    pr = '0;
    case (o)
      MDU_MULT:  p = sx * sy;
      MDU_MULTU: p = {32'd0, x} * {32'd0, y};
      MDU_DIV: begin
        q = sx / sy; r = sx % sy;
        p = q; pr = r;
      end
      default: begin
        p = {32'd0, x / y}; pr = {32'd0, x % y};
      end
    endcase
    if (o[1] && y == 32'd0) begin
      eh = x; el = 32'hFFFF_FFFF;
    end else if (o[1]) begin
      eh = pr[31:0]; el = p[31:0];
    end else begin
      eh = p[63:32]; el = p[31:0];
    end
  endfunction

  // Called at a negedge; returns at the negedge just after the start edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    chk("done_single_pulse", done, 1'b0);
  endtask

  task automatic wait_result(input string name, input logic [31:0] eh, el, input int n0);
    int n = n0;
    int bc = 0;
    bit held = 1'b1;
    while (done !== 1'b1 && n < 60) begin
      if (busy === 1'b1) bc++;
      if (hi !== m_hi || lo !== m_lo) held = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, n, 34);
    chk({name, " busy_cycles"}, bc, 34 - n0);
    chk({name, " busy_in_done"}, busy, 1'b0);
    chk({name, " hold"}, held, 1'b1);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    m_hi = eh; m_lo = el;
  endtask

  task automatic run_arith(input string name, input logic [2:0] o, input logic [31:0] x, y,
                           input logic [31:0] eh, el);
    issue(o, x, y);
    wait_result(name, eh, el, 1);
  endtask

  initial begin
    logic [31:0] eh, el, x, y;
    logic [2:0]  o;

    vecs.push_back('{"multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"mult_neg",  MDU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{"mult_min2", MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{"div_neg",   MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"div_negb",  MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{"divu_zero", MDU_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF});
    vecs.push_back('{"div_zero",  MDU_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF});
    vecs.push_back('{"divu_big",  MDU_DIVU,  32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF});

    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;

    // Directed table, issued back-to-back in each done cycle
    for (int i = 0; i < vecs.size(); i++)
      run_arith(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; op = MDU_MTHI; a = 32'h1234_5678;
    @(negedge clk);
    chk("mthi hi", hi, 32'h1234_5678);
    chk("mthi busy", busy, 1'b0);
    op = MDU_MTLO; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo lo", lo, 32'h9ABC_DEF0);
    chk("mtlo hi", hi, 32'h1234_5678);
    chk("mtlo busy", busy, 1'b0);
    chk("mtlo done", done, 1'b0);
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

    // Op codes 6/7 do nothing
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    chk("nop busy", busy, 1'b0);
    chk("nop hi", hi, m_hi);
    chk("nop lo", lo, m_lo);
    @(negedge clk);
    chk("nop idle", busy, 1'b0);

    // Signed overflow with a stray start mid-RUN
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    start = 1'b1; op = MDU_MULTU; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_result("div_ovf", 32'h0000_0000, 32'h8000_0000, 6);

    // Reset during RUN iteration 10, then DIVU 100/7
    issue(MDU_MULTU, 32'h0001_2345, 32'h0000_FFFF);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    run_arith("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 5))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 300));
        2:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) x = 32'($urandom_range(0, 1000));
      model(o, x, y, eh, el);
      run_arith($sformatf("rand%0d_op%0d", i, o), o, x, y, eh, el);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
